// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage data cache.
package mips_mem_pkg;

   // Controller states: idle/hit service, read refill, write-through store, release cycle
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR      = 2'd2,
      DONE    = 2'd3
   } cache_state_e;

   localparam int OFF_BITS = 2;

   // One-hot byte-lane enable for a byte access at the given offset
   function automatic logic [3:0] byte_en(input logic [OFF_BITS-1:0] off);
      byte_en = 4'b0001 << off;
   endfunction

   // Sign-extended byte lane 'off' of a little-endian word
   function automatic logic [31:0] lb_extract(input logic [31:0] word,
                                              input logic [OFF_BITS-1:0] off);
      logic [7:0] b;
      b = 8'(word >> {off, 3'b000});
      lb_extract = {{24{b[7]}}, b};
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid bits (async clear), tags and one data word per line.
// One asynchronous read port and one byte-masked write port.
module cache_line_array #(
   parameter int INDEX_BITS = 6
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic [INDEX_BITS-1:0]   rd_idx,
   output logic                    rd_valid,
   output logic [29-INDEX_BITS:0]  rd_tag,
   output logic [31:0]             rd_data,
   input  logic                    wr_en,
   input  logic [INDEX_BITS-1:0]   wr_idx,
   input  logic [29-INDEX_BITS:0]  wr_tag,
   input  logic [3:0]              wr_mask,
   input  logic [31:0]             wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]        valid_q;
   logic [29-INDEX_BITS:0]  tag_q  [LINES];
   logic [31:0]             data_q [LINES];

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

   // Valid bits: cleared by reset, set by any line write
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data storage, data written per enabled byte lane; not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx] <= wr_tag;
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mem_stage_cache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, write-through, no-write-allocate,
// one word per line, main memory behind a req/ack handshake. Freezes the pipeline
// while a read miss or a store is outstanding.
module mem_stage_cache_ctrl
   import mips_mem_pkg::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        cache_en,
   input  logic        mem_write,
   input  logic        is_LB_SB,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        freeze,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int TAG_W = 30 - INDEX_BITS;

   cache_state_e          state_q;

   logic [OFF_BITS-1:0]   off;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;

   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [31:0]           line_data;
   logic                  hit;

   logic                  arr_we;
   logic [3:0]            arr_mask;
   logic [31:0]           arr_wdata;
   logic                  load_out;

   assign off = addr[OFF_BITS-1:0];
   assign idx = addr[INDEX_BITS+1:2];
   assign tag = addr[31:INDEX_BITS+2];
   assign hit = line_valid && (line_tag == tag);

   cache_line_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_lines (
      .clk      (clk),
      .rst_b    (rst_b),
      .rd_idx   (idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (arr_we),
      .wr_idx   (idx),
      .wr_tag   (tag),
      .wr_mask  (arr_mask),
      .wr_data  (arr_wdata)
   );

   // Line update on ack: full refill for a read miss, byte-merge only for a store hit
   always_comb begin
      arr_we    = 1'b0;
      arr_mask  = 4'h0;
      arr_wdata = 32'h0;
      if (state_q == RD_MISS) begin
         arr_we    = mem_ack;
         arr_mask  = 4'hF;
         arr_wdata = mem_rdata;
      end else if (state_q == WR) begin
         arr_we    = mem_ack && hit;
         arr_mask  = mem_be;
         arr_wdata = mem_wdata;
      end
   end

   // Controller FSM and registered memory-request signals (held until ack)
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_be    <= 4'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cache_en && mem_write) begin
                  state_q   <= WR;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= is_LB_SB ? byte_en(off) : 4'hF;
                  mem_wdata <= is_LB_SB ? {4{wdata[7:0]}} : wdata;
               end else if (cache_en && !hit) begin
                  state_q   <= RD_MISS;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= 4'hF;
                  mem_wdata <= 32'h0;
               end
            end
            RD_MISS, WR: begin
               if (mem_ack) begin
                  state_q <= DONE;
                  mem_req <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Stall: a miss or store presented in IDLE, or a transaction in flight; gated by reset
   always_comb begin
      freeze = 1'b0;
      if (rst_b && cache_en) begin
         case (state_q)
            IDLE:        freeze = mem_write || !hit;
            RD_MISS, WR: freeze = 1'b1;
            default:     freeze = 1'b0;
         endcase
      end
   end

   // Load result straight from the line on a hit in IDLE or in the release cycle
   always_comb begin
      load_out = cache_en && !mem_write && hit &&
                 ((state_q == IDLE) || (state_q == DONE));
      rdata = 32'h0;
      if (load_out) begin
         rdata = is_LB_SB ? lb_extract(line_data, off) : line_data;
      end
   end

endmodule

// File: tb/tb_mem_stage_cache_ctrl.sv
// Randomized bench for mem_stage_cache_ctrl against an array/memory reference model.
module tb_mem_stage_cache_ctrl;

   logic        clk;
   logic        rst_b;
   logic        cache_en;
   logic        mem_write;
   logic        is_LB_SB;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        freeze;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: 64 lines, tag = addr[31:8], plus a sparse word memory
   bit          mvalid [64];
   logic [23:0] mtag   [64];
   logic [31:0] mline  [64];
   logic [31:0] mem    [logic [31:0]];

   mem_stage_cache_ctrl #(.INDEX_BITS(6)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .cache_en  (cache_en),
      .mem_write (mem_write),
      .is_LB_SB  (is_LB_SB),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .freeze    (freeze),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] get_mem(input logic [31:0] wa);
      if (!mem.exists(wa)) mem[wa] = $urandom;
      return mem[wa];
   endfunction

   function automatic logic [31:0] sext8(input logic [31:0] w, input logic [1:0] o);
      logic [31:0] b;
      b = (w >> (8 * o)) & 32'hFF;
      return (b >= 32'h80) ? (b - 32'h100) : b;
   endfunction

   // One load or store presented in IDLE (caller sits on a negedge); returns on a negedge
   task automatic do_access(input bit wr, input bit lb, input logic [31:0] a,
                            input logic [31:0] wd, input int dly);
      logic [5:0]  i;
      logic [23:0] t;
      logic [1:0]  o;
      logic [31:0] wa, word, expv, wd_exp, m32, nw;
      logic [3:0]  be_exp;
      bit          hit;
      i = a[7:2]; t = a[31:8]; o = a[1:0]; wa = {a[31:2], 2'b00};
      hit = mvalid[i] && (mtag[i] == t);
      cache_en = 1'b1; mem_write = wr; is_LB_SB = lb; addr = a; wdata = wd;
      #1;
      if (!wr && hit) begin
         expv = lb ? sext8(mline[i], o) : mline[i];
         n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL hit_freeze a=%h: got %b want 0", a, freeze); end
         n_cmp++; if (rdata !== expv) begin n_fail++; $display("FAIL hit_rdata a=%h: got %h want %h", a, rdata, expv); end
         n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_req a=%h: got %b want 0", a, mem_req); end
         @(negedge clk);
      end else begin
         n_cmp++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL idle_freeze a=%h: got %b want 1", a, freeze); end
         n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata a=%h: got %h want 0", a, rdata); end
         @(negedge clk); #1;
         n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL req_up a=%h: got %b want 1", a, mem_req); end
         n_cmp++; if (mem_we !== wr) begin n_fail++; $display("FAIL req_we a=%h: got %b want %b", a, mem_we, wr); end
         n_cmp++; if (mem_addr !== wa) begin n_fail++; $display("FAIL req_addr: got %h want %h", mem_addr, wa); end
         if (wr) begin
            be_exp = lb ? (4'b0001 << o) : 4'hF;
            wd_exp = lb ? (wd & 32'hFF) * 32'h01010101 : wd;
            n_cmp++; if (mem_be !== be_exp) begin n_fail++; $display("FAIL req_be a=%h: got %b want %b", a, mem_be, be_exp); end
            n_cmp++; if (mem_wdata !== wd_exp) begin n_fail++; $display("FAIL req_wdata a=%h: got %h want %h", a, mem_wdata, wd_exp); end
         end
         for (int k = 0; k < dly; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== wa || freeze !== 1'b1) begin
               n_fail++; $display("FAIL req_hold a=%h: req=%b addr=%h freeze=%b want 1/%h/1", a, mem_req, mem_addr, freeze, wa);
            end
         end
         word = get_mem(wa);
         mem_ack = 1'b1;
         mem_rdata = wr ? $urandom : word;
         @(negedge clk);
         mem_ack = 1'b0;
         #1;
         if (!wr) begin
            mvalid[i] = 1'b1; mtag[i] = t; mline[i] = word;
            expv = lb ? sext8(word, o) : word;
         end else begin
            m32 = lb ? (32'hFF << (8 * o)) : 32'hFFFF_FFFF;
            nw = (word & ~m32) | ((lb ? (wd & 32'hFF) * 32'h01010101 : wd) & m32);
            mem[wa] = nw;
            if (hit) mline[i] = nw;
            expv = 32'h0;
         end
         n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL done_freeze a=%h: got %b want 0", a, freeze); end
         n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL done_req a=%h: got %b want 0", a, mem_req); end
         n_cmp++; if (rdata !== expv) begin n_fail++; $display("FAIL done_rdata a=%h: got %h want %h", a, rdata, expv); end
         @(negedge clk);
      end
   endtask

   task automatic idle_cycle();
      cache_en = 1'b0; mem_write = $urandom_range(0, 1); is_LB_SB = $urandom_range(0, 1);
      addr = 32'h100; wdata = $urandom;
      #1;
      n_cmp++; if (freeze !== 1'b0 || rdata !== 32'h0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL idle: freeze=%b rdata=%h req=%b want 0/0/0", freeze, rdata, mem_req);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_b = 1'b0; cache_en = 1'b1; mem_write = 1'b1; is_LB_SB = 1'b0;
      addr = 32'h100; wdata = 32'h1; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
      n_cmp++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %b want 0", mem_be); end
      n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL rst_freeze: got %b want 0", freeze); end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      @(negedge clk);
      cache_en = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cold_miss_and_hit();
      mem[32'h100] = 32'hDEADBEEF;
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 3);
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 0);
      idle_cycle();
   endtask

   task automatic test_store_byte();
      do_access(1'b1, 1'b1, 32'h102, 32'h55, 1);
      n_cmp++; if (mline[0] !== 32'hDE55BEEF) begin n_fail++; $display("FAIL sb_model: got %h want DE55BEEF", mline[0]); end
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 0);
      do_access(1'b1, 1'b0, 32'h100, 32'h00800000, 0);
      do_access(1'b0, 1'b1, 32'h102, 32'h0, 0);
   endtask

   task automatic test_store_miss();
      do_access(1'b1, 1'b0, 32'h200, 32'h12345678, 0);
      do_access(1'b0, 1'b0, 32'h200, 32'h0, 2);
   endtask

   task automatic test_alias();
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 1);
      do_access(1'b0, 1'b0, 32'h200, 32'h0, 0);
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 2);
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 0);
   endtask

   task automatic test_reset_mid_miss();
      cache_en = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; addr = 32'h300; wdata = 32'h0;
      @(negedge clk); #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_up: got %b want 1", mem_req); end
      rst_b = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
      n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL mid_freeze_drop: got %b want 0", freeze); end
      for (int k = 0; k < 64; k++) mvalid[k] = 1'b0;
      @(negedge clk);
      cache_en = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = $urandom;
      #1;
      n_cmp++; if (mem_req !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL late_ack: req=%b freeze=%b want 0/0", mem_req, freeze); end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL late_ack_after: got %b want 0", mem_req); end
      @(negedge clk);
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 6) == 0) begin
            idle_cycle();
         end else begin
            a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_access($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom,
                      $urandom_range(0, 3));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mvalid[k] = 1'b0;
      test_reset();
      test_cold_miss_and_hit();
      test_store_byte();
      test_store_miss();
      test_alias();
      test_reset_mid_miss();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
